immgen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the decode path. It takes one 32-bit RV instruction per handshake and extracts its immediate, sign- or zero-extended to XLEN. Alongside the immediate it reports the immediate format and an illegal-encoding flag. A valid/ready pipeline register with an optional skid buffer lets it sit between fetch and the register-read stage without a combinational ready path.

---
 rtl/immgen_stage.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_immgen_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immgen_stage.sv
// rtl/immgen_stage.sv - registered RV immediate-generation stage with optional skid buffer
//
// Extracts the immediate of one 32-bit RV instruction per handshake, extended
// to XLEN, together with its format code and an illegal-encoding flag. The
// decode result is registered behind a valid/ready pipeline stage.
//
// Parameters:
//   XLEN        datapath width, 32 or 64
//   SKID        1: two-entry skid buffer, registered ready_o
//               0: single register, combinational ready_o
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   instr_i     instruction word
//   valid_i     instr_i is valid
//   ready_o     stage can accept an instruction
//   flush_i     synchronous kill of all buffered entries
//   valid_o     output entry is valid
//   ready_i     downstream accepts the output entry
//   imm_o       extended immediate
//   imm_type_o  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH
//   illegal_o   instruction not decodable by this stage

module immgen_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     instr_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;
  localparam logic [2:0] IMM_Z    = 3'd6;
  localparam logic [2:0] IMM_SH   = 3'd7;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [4:0]      opc;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;

  assign opc      = instr_i[6:2];
  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_imm  = '0;
    dec_type = IMM_NONE;
    dec_ill  = 1'b0;

    case (opc)
      OPC_LOAD, OPC_JALR: begin
        dec_type = IMM_I;
        dec_imm  = XLEN'($signed(instr_i[31:20]));
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          // RV32 shifts only have a 5-bit shamt; bit 25 set is reserved
          if (!RV64 && instr_i[25]) begin
            dec_ill = 1'b1;
          end else begin
            dec_type = IMM_SH;
            dec_imm  = RV64 ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
          end
        end else begin
          dec_type = IMM_I;
          dec_imm  = XLEN'($signed(instr_i[31:20]));
        end
      end
      OPC_OP_IMM_32: begin
        if (!RV64) begin
          dec_ill = 1'b1;
        end else if (is_shift) begin
          // word shifts are always 5-bit
          if (instr_i[25]) begin
            dec_ill = 1'b1;
          end else begin
            dec_type = IMM_SH;
            dec_imm  = XLEN'(instr_i[24:20]);
          end
        end else begin
          dec_type = IMM_I;
          dec_imm  = XLEN'($signed(instr_i[31:20]));
        end
      end
      OPC_STORE: begin
        dec_type = IMM_S;
        dec_imm  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      end
      OPC_BRANCH: begin
        dec_type = IMM_B;
        dec_imm  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                  instr_i[11:8], 1'b0}));
      end
      OPC_JAL: begin
        dec_type = IMM_J;
        dec_imm  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                  instr_i[30:21], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_type = IMM_U;
        dec_imm  = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      OPC_SYSTEM: begin
        // CSR*I forms carry a 5-bit unsigned immediate in the rs1 field
        if (funct3[2]) begin
          dec_type = IMM_Z;
          dec_imm  = XLEN'(instr_i[19:15]);
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
        dec_type = IMM_NONE;
      end
      OPC_OP_32: begin
        dec_ill = !RV64;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase

    if (instr_i[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end

    if (dec_ill) begin
      dec_imm  = '0;
      dec_type = IMM_NONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  if (SKID != 0) begin : g_skid
    state_t          state_q, state_d;
    logic            ready_q;
    logic            accept, drain;
    logic            load_main_dec, load_main_skid, load_skid;
    logic [XLEN-1:0] main_imm_q, skid_imm_q;
    logic [2:0]      main_type_q, skid_type_q;
    logic            main_ill_q, skid_ill_q;

    assign accept = valid_i && ready_q;
    assign drain  = (state_q != ST_EMPTY) && ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        // ready is a pure flop of the next state, so nothing downstream
        // reaches combinationally into the upstream ready path
        ready_q <= (state_d != ST_TWO);
      end
    end

    always_comb begin
      state_d        = state_q;
      load_main_dec  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d       = ST_ONE;
              load_main_dec = 1'b1;
            end
          end
          ST_ONE: begin
            if (accept && drain) begin
              load_main_dec = 1'b1;
            end else if (accept) begin
              state_d   = ST_TWO;
              load_skid = 1'b1;
            end else if (drain) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (drain) begin
              state_d        = ST_ONE;
              load_main_skid = 1'b1;
            end
          end
          default: begin
            state_d = ST_EMPTY;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_imm_q  <= '0;
        main_type_q <= IMM_NONE;
        main_ill_q  <= 1'b0;
        skid_imm_q  <= '0;
        skid_type_q <= IMM_NONE;
        skid_ill_q  <= 1'b0;
      end else begin
        if (load_main_dec) begin
          main_imm_q  <= dec_imm;
          main_type_q <= dec_type;
          main_ill_q  <= dec_ill;
        end else if (load_main_skid) begin
          main_imm_q  <= skid_imm_q;
          main_type_q <= skid_type_q;
          main_ill_q  <= skid_ill_q;
        end
        if (load_skid) begin
          skid_imm_q  <= dec_imm;
          skid_type_q <= dec_type;
          skid_ill_q  <= dec_ill;
        end
      end
    end

    assign ready_o    = ready_q;
    assign valid_o    = (state_q != ST_EMPTY);
    assign imm_o      = main_imm_q;
    assign imm_type_o = main_type_q;
    assign illegal_o  = main_ill_q;
  end else begin : g_single
    logic            valid_q;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      type_q;
    logic            ill_q;

    // accept is allowed in the same cycle the held entry drains
    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        imm_q   <= '0;
        type_q  <= IMM_NONE;
        ill_q   <= 1'b0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (valid_i && ready_o) begin
        valid_q <= 1'b1;
        imm_q   <= dec_imm;
        type_q  <= dec_type;
        ill_q   <= dec_ill;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end

    assign valid_o    = valid_q;
    assign imm_o      = imm_q;
    assign imm_type_o = type_q;
    assign illegal_o  = ill_q;
  end

endmodule

// File: tb/tb_immgen_stage.sv
// tb/tb_immgen_stage.sv - scoreboard bench for immgen_stage (XLEN32/SKID1 and XLEN64/SKID0)

module tb_immgen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // instance a: XLEN=32, SKID=1
  logic [31:0] instr_a;
  logic        valid_a, ready_a, flush_a, valid_oa, rdy_ia, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  type_a;

  // instance b: XLEN=64, SKID=0
  logic [31:0] instr_b;
  logic        valid_b, ready_b, flush_b, valid_ob, rdy_ib, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  type_b;

  immgen_stage #(.XLEN(32), .SKID(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr_a), .valid_i(valid_a),
    .ready_o(ready_a), .flush_i(flush_a), .valid_o(valid_oa), .ready_i(rdy_ia),
    .imm_o(imm_a), .imm_type_o(type_a), .illegal_o(ill_a)
  );

  immgen_stage #(.XLEN(64), .SKID(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr_b), .valid_i(valid_b),
    .ready_o(ready_b), .flush_i(flush_b), .valid_o(valid_ob), .ready_i(rdy_ib),
    .imm_o(imm_b), .imm_type_o(type_b), .illegal_o(ill_b)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    exp_t        e32;
    exp_t        e64;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vq[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input logic [31:0] ins,
                         input logic [63:0] i32, input logic [2:0] t32, input logic l32,
                         input logic [63:0] i64, input logic [2:0] t64, input logic l64);
    vec_t v;
    v.ins = ins;
    v.e32 = '{imm: i32, typ: t32, ill: l32};
    v.e64 = '{imm: i64, typ: t64, ill: l64};
    vq.push_back(v);
  endtask

  // Drive at negedge, decide acceptance at +3 (ready inputs only move at +1),
  // record the expectation once the accepting edge has passed.
  task automatic send_a(input logic [31:0] ins, input exp_t e);
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      instr_a = ins;
      valid_a = 1'b1;
      #3;
      if (ready_a && !flush_a) begin
        @(posedge clk);
        q_a.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL send_a_timeout: instr 0x%08h never accepted", ins);
    end
  endtask

  task automatic send_b(input logic [31:0] ins, input exp_t e);
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      instr_b = ins;
      valid_b = 1'b1;
      #3;
      if (ready_b && !flush_b) begin
        @(posedge clk);
        q_b.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL send_b_timeout: instr 0x%08h never accepted", ins);
    end
  endtask

  task automatic idle_a();
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic idle_b();
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  // Monitors: compare every output transfer against the scoreboard head.
  always begin : mon_a
    exp_t e;
    @(negedge clk);
    #4;
    if (rst_n && valid_oa && rdy_ia) begin
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL a_unexpected: output imm=0x%0h type=%0d with empty scoreboard", imm_a, type_a);
      end else begin
        e = q_a.pop_front();
        chk("a_imm", {32'b0, imm_a}, e.imm);
        chk("a_type", 64'(type_a), 64'(e.typ));
        chk("a_ill", 64'(ill_a), 64'(e.ill));
      end
    end
  end

  always begin : mon_b
    exp_t e;
    @(negedge clk);
    #4;
    if (rst_n && valid_ob && rdy_ib) begin
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected: output imm=0x%0h type=%0d with empty scoreboard", imm_b, type_b);
      end else begin
        e = q_b.pop_front();
        chk("b_imm", imm_b, e.imm);
        chk("b_type", 64'(type_b), 64'(e.typ));
        chk("b_ill", 64'(ill_b), 64'(e.ill));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ea, eb, ec;
    rst_n   = 1'b0;
    instr_a = '0; valid_a = 1'b0; flush_a = 1'b0; rdy_ia = 1'b1;
    instr_b = '0; valid_b = 1'b0; flush_b = 1'b0; rdy_ib = 1'b1;

    //          instr         imm32               t  il  imm64                  t  il
    add_vec(32'hFFF00093, 64'hFFFFFFFF,       1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0); // addi -1
    add_vec(32'hFE000EE3, 64'hFFFFFFFC,       3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0); // beq -4
    add_vec(32'h800000B7, 64'h80000000,       4, 0, 64'hFFFFFFFF80000000, 4, 0); // lui
    add_vec(32'h300FD073, 64'h1F,             6, 0, 64'h1F,               6, 0); // csrrwi
    add_vec(32'h02009093, 64'h0,              0, 1, 64'h20,               7, 0); // slli 32
    add_vec(32'h00000001, 64'h0,              0, 1, 64'h0,                0, 1); // compressed
    add_vec(32'h0000007F, 64'h0,              0, 1, 64'h0,                0, 1); // opc 11111
    add_vec(32'hFE112E23, 64'hFFFFFFFC,       2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0); // sw -4
    add_vec(32'h0080006F, 64'h8,              5, 0, 64'h8,                5, 0); // jal +8
    add_vec(32'hFFF0809B, 64'h0,              0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0); // addiw -1
    add_vec(32'h0200909B, 64'h0,              0, 1, 64'h0,                0, 1); // slliw 32
    add_vec(32'h0050D093, 64'h5,              7, 0, 64'h5,                7, 0); // srli 5
    add_vec(32'h4210D093, 64'h0,              0, 1, 64'h21,               7, 0); // srai 33
    add_vec(32'h002080B3, 64'h0,              0, 0, 64'h0,                0, 0); // add
    add_vec(32'h30009073, 64'h0,              0, 0, 64'h0,                0, 0); // csrrw
    add_vec(32'h002080BB, 64'h0,              0, 1, 64'h0,                0, 0); // addw

    // reset state
    #12;
    chk("rst_a_valid", 64'(valid_oa), 0);
    chk("rst_a_ready", 64'(ready_a), 1);
    chk("rst_a_imm", 64'(imm_a), 0);
    chk("rst_a_type", 64'(type_a), 0);
    chk("rst_a_ill", 64'(ill_a), 0);
    chk("rst_b_valid", 64'(valid_ob), 0);
    chk("rst_b_ready", 64'(ready_b), 1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // decode table streamed back-to-back into both instances
    fork
      begin
        foreach (vq[i]) send_a(vq[i].ins, vq[i].e32);
        idle_a();
      end
      begin
        foreach (vq[i]) send_b(vq[i].ins, vq[i].e64);
        idle_b();
      end
    join
    repeat (3) @(negedge clk);
    chk("p1_a_drained", 64'(q_a.size()), 0);
    chk("p1_b_drained", 64'(q_b.size()), 0);

    ea = vq[0].e32; eb = vq[1].e32; ec = vq[2].e32;

    // SKID=1 backpressure: A and B accepted, C held until release
    @(negedge clk);
    #1 rdy_ia = 1'b0;
    fork
      begin
        send_a(vq[0].ins, ea);
        send_a(vq[1].ins, eb);
        send_a(vq[2].ins, ec);
        idle_a();
      end
      begin
        repeat (3) @(negedge clk);
        #2;
        chk("bp_a_ready_full", 64'(ready_a), 0);
        chk("bp_a_valid_stall", 64'(valid_oa), 1);
        @(negedge clk);
        #1 rdy_ia = 1'b1;
        #1 chk("bp_a_ready_reg", 64'(ready_a), 0);
        @(negedge clk);
        #2 chk("bp_a_nogap1", 64'(valid_oa), 1);
        @(negedge clk);
        #2 chk("bp_a_nogap2", 64'(valid_oa), 1);
        @(negedge clk);
        #2 chk("bp_a_nodup", 64'(valid_oa), 0);
      end
    join

    // SKID=0 backpressure: ready_o tracks ready_i without a clock edge
    @(negedge clk);
    #1 rdy_ib = 1'b0;
    fork
      begin
        send_b(vq[3].ins, vq[3].e64);
        send_b(vq[4].ins, vq[4].e64);
        send_b(vq[7].ins, vq[7].e64);
        idle_b();
      end
      begin
        repeat (2) @(negedge clk);
        #1 chk("bp_b_ready_lo", 64'(ready_b), 0);
        rdy_ib = 1'b1;
        #1 chk("bp_b_ready_follow_hi", 64'(ready_b), 1);
        @(negedge clk);
        #1 rdy_ib = 1'b0;
        #1 chk("bp_b_ready_follow_lo", 64'(ready_b), 0);
        @(negedge clk);
        #1 rdy_ib = 1'b1;
        #1 chk("bp_b_ready_follow_hi2", 64'(ready_b), 1);
      end
    join
    repeat (3) @(negedge clk);
    chk("p3_a_drained", 64'(q_a.size()), 0);
    chk("p3_b_drained", 64'(q_b.size()), 0);

    // flush in TWO with an offered input (a); flush with a would-be accept (b)
    @(negedge clk);
    #1 rdy_ia = 1'b0;
    send_a(vq[8].ins, vq[8].e32);
    send_a(vq[11].ins, vq[11].e32);
    send_b(vq[9].ins, vq[9].e64);
    @(negedge clk);
    instr_a = vq[0].ins; valid_a = 1'b1; flush_a = 1'b1;
    instr_b = vq[1].ins; valid_b = 1'b1; flush_b = 1'b1;
    @(posedge clk);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    flush_a = 1'b0; valid_a = 1'b0;
    flush_b = 1'b0; valid_b = 1'b0;
    #2;
    chk("flush_a_valid", 64'(valid_oa), 0);
    chk("flush_a_ready", 64'(ready_a), 1);
    chk("flush_b_valid", 64'(valid_ob), 0);
    chk("flush_b_ready", 64'(ready_b), 1);
    rdy_ia = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("flush_a_none", 64'(valid_oa), 0);
    chk("flush_b_none", 64'(valid_ob), 0);

    // async reset mid-stall
    @(negedge clk);
    #1 rdy_ia = 1'b0;
    send_a(vq[2].ins, vq[2].e32);
    send_a(vq[1].ins, vq[1].e32);
    idle_a();
    #2 rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk("arst_a_valid", 64'(valid_oa), 0);
    chk("arst_a_ready", 64'(ready_a), 1);
    chk("arst_a_imm", 64'(imm_a), 0);
    chk("arst_a_type", 64'(type_a), 0);
    chk("arst_a_ill", 64'(ill_a), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rdy_ia = 1'b1;
    send_a(vq[7].ins, vq[7].e32);
    idle_a();
    repeat (3) @(negedge clk);
    chk("end_a_drained", 64'(q_a.size()), 0);
    chk("end_b_drained", 64'(q_b.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
